// File: rtl/regfile_sb.sv
// Parametrised register file with two bypassed read ports, a byte-strobed write
// port and a write-pending scoreboard for issue-stage hazard stalls.

module regfile_sb_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_regs,
  input  logic [DEPTH-1:0]            i_sb,
  input  logic [AW-1:0]               i_raddr,
  input  logic                        i_wr_ok,
  input  logic [AW-1:0]               i_waddr,
  input  logic [WIDTH-1:0]            i_merged,
  output logic [WIDTH-1:0]            o_rdata,
  output logic                        o_busy
);
  logic w_hit;

  assign w_hit = i_wr_ok && (i_waddr == i_raddr);

  always_comb begin
    o_rdata = i_regs[i_raddr];
    if ((ZERO_REG != 0) && (i_raddr == '0)) o_rdata = '0;
    else if (w_hit)                         o_rdata = i_merged;
  end

  // The writeback landing this cycle already resolves the hazard.
  assign o_busy = i_sb[i_raddr] && !w_hit;
endmodule

module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int SW      = WIDTH / 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic             o_busy_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic             o_busy_b,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [SW-1:0]    i_wstrb,
  input  logic             i_issue,
  input  logic [AW-1:0]    i_issue_addr,
  output logic             o_busy_any
);
  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]            r_sb;
  logic [DEPTH-1:0]            w_sb_nxt;
  logic [WIDTH-1:0]            w_merged;
  logic                        w_wr_ok;
  logic                        w_iss_ok;
  logic [1:0][AW-1:0]          w_raddr;
  logic [1:0][WIDTH-1:0]       w_rdata;
  logic [1:0]                  w_busy;

  assign w_wr_ok  = i_we    && !((ZERO_REG != 0) && (i_waddr == '0));
  assign w_iss_ok = i_issue && !((ZERO_REG != 0) && (i_issue_addr == '0));

  always_comb begin
    w_merged = r_regs[i_waddr];
    for (int k = 0; k < SW; k++)
      if (i_wstrb[k]) w_merged[8*k +: 8] = i_wdata[8*k +: 8];
  end

  // Set is applied after clear so a same-address issue stays outstanding.
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_wr_ok)  w_sb_nxt[i_waddr]      = 1'b0;
    if (w_iss_ok) w_sb_nxt[i_issue_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_regs <= '0;
      r_sb   <= '0;
    end else begin
      if (w_wr_ok) r_regs[i_waddr] <= w_merged;
      r_sb <= w_sb_nxt;
    end
  end

  assign w_raddr = {i_raddr_b, i_raddr_a};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    regfile_sb_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd (
      .i_regs   (r_regs),
      .i_sb     (r_sb),
      .i_raddr  (w_raddr[g]),
      .i_wr_ok  (w_wr_ok),
      .i_waddr  (i_waddr),
      .i_merged (w_merged),
      .o_rdata  (w_rdata[g]),
      .o_busy   (w_busy[g])
    );
  end

  assign o_rdata_a  = w_rdata[0];
  assign o_rdata_b  = w_rdata[1];
  assign o_busy_a   = w_busy[0];
  assign o_busy_b   = w_busy[1];
  assign o_busy_any = |r_sb;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an
// array-based reference of the register and scoreboard rules.

module tb_regfile_sb;
  localparam int WIDTH = 32, DEPTH = 32, ZERO_REG = 1, AW = 5, SW = 4;

  logic             clk = 1'b0;
  logic             reset, we, issue;
  logic [AW-1:0]    raddr_a, raddr_b, waddr, issue_addr;
  logic [WIDTH-1:0] wdata, rdata_a, rdata_b;
  logic [SW-1:0]    wstrb;
  logic             busy_a, busy_b, busy_any;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_sb   [DEPTH];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_raddr_a(raddr_a), .o_rdata_a(rdata_a), .o_busy_a(busy_a),
    .i_raddr_b(raddr_b), .o_rdata_b(rdata_b), .o_busy_b(busy_b),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wstrb(wstrb),
    .i_issue(issue), .i_issue_addr(issue_addr), .o_busy_any(busy_any)
  );

  function automatic bit is_zero(input int a);
    return (ZERO_REG != 0) && (a == 0);
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] d,
                                             input logic [SW-1:0] s);
    logic [WIDTH-1:0] v = old;
    for (int k = 0; k < SW; k++) if (s[k]) v[8*k +: 8] = d[8*k +: 8];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    if (is_zero(a)) return '0;
    if (we && int'(waddr) == a) return merge(m_regs[a], wdata, wstrb);
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return m_sb[a] && !(we && int'(waddr) == a && !is_zero(a));
  endfunction

  function automatic bit exp_any();
    bit r = 0;
    for (int i = 0; i < DEPTH; i++) r |= m_sb[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin m_regs[i] = '0; m_sb[i] = 0; end
    end else begin
      if (we && !is_zero(waddr)) begin
        m_regs[waddr] = merge(m_regs[waddr], wdata, wstrb);
        m_sb[waddr] = 0;
      end
      if (issue && !is_zero(issue_addr)) m_sb[issue_addr] = 1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; we = 0; issue = 0; waddr = '0; wdata = '0; wstrb = '0; issue_addr = '0;
  endtask

  task automatic test_reset();
    idle(); raddr_a = '0; raddr_b = '0;
    reset = 1; tick(); reset = 0;
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; wstrb = 4'hF; tick();
    we = 0; issue = 1; issue_addr = 5; raddr_a = 5; #1;
    checks++;
    if (rdata_a !== 32'hDEADBEEF) begin errors++;
      $display("FAIL preload rdata_a got %h want deadbeef", rdata_a); end
    tick(); issue = 0;
    reset = 1; tick(); reset = 0; raddr_b = 5; #1;
    checks++;
    if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
    checks++;
    if (busy_any !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++;
      $display("FAIL reset_busy got any=%b a=%b b=%b want 0", busy_any, busy_a, busy_b); end
  endtask

  task automatic test_strobe();
    idle();
    we = 1; waddr = 3; wdata = 32'h11223344; wstrb = 4'hF; tick();
    wdata = 32'hAABBCCDD; wstrb = 4'h5; raddr_b = 3; #1;
    checks++;
    if (rdata_b !== 32'h11BB33DD) begin errors++;
      $display("FAIL strobe_bypass got %h want 11bb33dd", rdata_b); end
    tick(); idle(); raddr_a = 3; #1;
    checks++;
    if (rdata_a !== 32'h11BB33DD) begin errors++;
      $display("FAIL strobe_stored got %h want 11bb33dd", rdata_a); end
  endtask

  task automatic test_zero();
    idle();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; issue = 1; issue_addr = 0; raddr_a = 0; #1;
    checks++;
    if (rdata_a !== 32'h0 || busy_a !== 1'b0) begin errors++;
      $display("FAIL zero_same_cycle got %h/%b want 0/0", rdata_a, busy_a); end
    tick(); idle(); #1;
    checks++;
    if (rdata_a !== 32'h0 || busy_a !== 1'b0 || busy_any !== 1'b0) begin errors++;
      $display("FAIL zero_after got %h/%b/%b want 0/0/0", rdata_a, busy_a, busy_any); end
  endtask

  task automatic test_sb_lifecycle();
    idle();
    issue = 1; issue_addr = 7; tick(); idle(); raddr_a = 7; #1;
    checks++;
    if (busy_a !== 1'b1 || busy_any !== 1'b1) begin errors++;
      $display("FAIL sb_set got %b/%b want 1/1", busy_a, busy_any); end
    we = 1; waddr = 7; wstrb = 4'h0; wdata = 32'hFFFFFFFF; #1;
    checks++;
    if (busy_a !== 1'b0 || busy_any !== 1'b1) begin errors++;
      $display("FAIL sb_wb_comb got %b/%b want 0/1", busy_a, busy_any); end
    tick(); idle(); #1;
    checks++;
    if (busy_a !== 1'b0 || busy_any !== 1'b0) begin errors++;
      $display("FAIL sb_cleared got %b/%b want 0/0", busy_a, busy_any); end
  endtask

  task automatic test_set_clear();
    idle();
    issue = 1; issue_addr = 9; tick();
    we = 1; waddr = 9; wdata = 32'h42; wstrb = 4'hF; tick(); idle(); raddr_a = 9; #1;
    checks++;
    if (rdata_a !== 32'h42 || busy_a !== 1'b1) begin errors++;
      $display("FAIL set_wins got %h/%b want 00000042/1", rdata_a, busy_a); end
    we = 1; waddr = 9; wstrb = 4'h0; tick(); idle();
  endtask

  task automatic test_dual_port();
    idle();
    we = 1; wstrb = 4'hF; waddr = 1; wdata = 32'h1; tick();
    waddr = 2; wdata = 32'h2; tick();
    raddr_a = 1; raddr_b = 2; waddr = 2; wdata = 32'h5; #1;
    checks++;
    if (rdata_a !== 32'h1 || rdata_b !== 32'h5) begin errors++;
      $display("FAIL dual_port got %h/%h want 1/5", rdata_a, rdata_b); end
    tick(); idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 60) == 0);
      we = $urandom_range(0, 1); issue = $urandom_range(0, 1);
      waddr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      issue_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wdata = $urandom; wstrb = SW'($urandom);
      raddr_a = $urandom_range(0, 2) == 0 ? waddr : AW'($urandom_range(0, 3));
      raddr_b = $urandom_range(0, 2) == 0 ? issue_addr : AW'($urandom);
      #1;
      checks++;
      if (rdata_a !== exp_rd(raddr_a) || rdata_b !== exp_rd(raddr_b)) begin errors++;
        $display("FAIL rand_rdata n=%0d got %h/%h want %h/%h", n, rdata_a, rdata_b,
                 exp_rd(raddr_a), exp_rd(raddr_b)); end
      checks++;
      if (busy_a !== exp_busy(raddr_a) || busy_b !== exp_busy(raddr_b) || busy_any !== exp_any()) begin
        errors++;
        $display("FAIL rand_busy n=%0d got %b%b%b want %b%b%b", n, busy_a, busy_b, busy_any,
                 exp_busy(raddr_a), exp_busy(raddr_b), exp_any()); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_zero();
    test_sb_lifecycle();
    test_set_clear();
    test_dual_port();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised CPU register file with a write-pending scoreboard. It generalises the single fixed 32-bit register block to DEPTH registers of WIDTH bits, with:
- two combinational read ports with write-through bypass;
- one byte-strobed write port;
- an optional hard-wired zero register;
- per-register busy bits that track in-flight writes, so the issue stage can stall on hazards.

It sits between decode/issue and writeback in the CPU datapath.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two, at least 2.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Address width AW = log2(DEPTH); strobe width SW = WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset: synchronous, active-high, one clock.
- raddr_a  in  AW  read port A address.
- rdata_a  out  WIDTH  read port A data, combinational.
- busy_a  out  1  register raddr_a has a pending write, combinational.
- raddr_b  in  AW  read port B address.
- rdata_b  out  WIDTH  read port B data, combinational.
- busy_b  out  1  register raddr_b has a pending write, combinational.
- we  in  1  writeback valid.
- waddr  in  AW  writeback address.
- wdata  in  WIDTH  writeback data.
- wstrb  in  SW  byte enables; bit k covers wdata[8k+7:8k].
- issue  in  1  instruction issued that will write issue_addr.
- issue_addr  in  AW  destination register of the issued instruction.
- busy_any  out  1  OR of all busy bits.

## Operation
- **Storage:** DEPTH x WIDTH array `regs`, plus DEPTH-bit vector `sb`.
- **Reset:** reset=1 at an edge clears all regs to 0 and all sb bits to 0. Reset overrides we and issue in the same cycle.
  - After the reset edge: every rdata is 0 (no bypass active), every busy output is 0, busy_any is 0.
- **Write:** on an edge with we=1, for each byte k with wstrb[k]=1, regs[waddr] byte k takes wdata byte k. Bytes with wstrb[k]=0 keep their old value.
- **Read port X (A and B identical, independent):**
  - If ZERO_REG=1 and raddr_X=0, rdata_X is 0.
  - Otherwise, if we=1 and waddr=raddr_X, rdata_X is the merged value: old regs bytes overlaid with strobed wdata bytes, in the same cycle (write-through bypass).
  - Otherwise rdata_X is regs[raddr_X].
- **Scoreboard:**
  - Edge with issue=1 sets sb[issue_addr].
  - Edge with we=1 clears sb[waddr], even when wstrb=0.
  - Same address, same edge: set wins. The new issue's write is still outstanding; the old one completes.
  - Different addresses: both updates apply.
  - issue to an already-busy register keeps it busy. Only one outstanding write per register is tracked; the issue stage must not rely on counting.
- **Busy outputs:** busy_X = sb[raddr_X] AND NOT (we=1 and waddr=raddr_X). The writeback in flight satisfies the hazard the same cycle, consistent with the bypass.
- **Zero register (ZERO_REG=1):** writes, issues and clears to address 0 are ignored. sb[0] stays 0 and busy for address 0 is 0.
- **busy_any:** OR of the registered sb vector only; no bypass term.

## Timing
- Read latency: 0 cycles (combinational from raddr, we, waddr, wdata, wstrb).
- Write visible through regs: cycle after the edge. Visible through the bypass: the same cycle.
- issue at edge N: busy visible from cycle N+1.
- Writeback at edge N: busy drops combinationally during cycle N; sb is cleared from N+1.
- No handshake back-pressure; we and issue are accepted every cycle.
- Reset mid-stream discards all pending scoreboard state and register contents at that edge.

## Test plan
- **Reset:** preload r5=0xDEADBEEF, assert reset 1 cycle -> rdata_a(raddr_a=5)=0, busy_any=0.
- **Byte-strobed write:** write r3=0x11223344 wstrb=0xF, then wdata=0xAABBCCDD wstrb=0x5 -> r3 reads 0x11BB33DD next cycle.
  - During the second write cycle, rdata_b(raddr_b=3) already shows 0x11BB33DD (bypass).
- **Zero register:** ZERO_REG=1, we=1 waddr=0 wdata=0xFFFFFFFF, issue=1 issue_addr=0 -> rdata_a(0)=0, busy_a=0, busy_any=0.
- **Scoreboard lifecycle:** issue r7 -> busy_a(raddr_a=7)=1 next cycle.
  - Writeback r7 with wstrb=0 -> busy_a=0 combinationally that cycle, and sb[7]=0 afterwards.
- **Simultaneous set/clear:** r9 busy; same edge issue r9 and writeback r9 0x00000042 -> next cycle rdata=0x42 and busy=1.
- **Dual-port independence:** r1=0x1, r2=0x2; raddr_a=1, raddr_b=2, writeback r2=0x5 the same cycle -> rdata_a=0x1, rdata_b=0x5.
